nor_bus_multi: RTL and testbench
================================

// Module: nor_bus_multi
// PURPOSE
//  Wishbone (pipelined, single-outstanding) slave driving NCHIPS parallel NOR devices sharing one addr/data bus.
//  Successor of the single-chip NOR driver, sitting below wb_nor_controller in the bridge.
//  Adds a per-chip CE decoded from upper address bits and parameterised setup/access/pulse/hold timing.
//  Adds per-chip RY/BY# synchronisation and a ready-wait timeout that terminates with wb_err_o.
// PARAMETERS
//  ADDRBITS   26     word address width per chip
//  DATABITS   16     NOR data width
//  NCHIPS     2      number of chips (1..8); CSBITS = max(1,$clog2(NCHIPS))
//  TSETUP     1      cycles addr/CE valid before OE/WE fall (>=1)
//  TRD        8      cycles OE low on read; data sampled on last one (>=1)
//  TWR        4      cycles WE low on write (>=1)
//  THOLD      1      cycles addr/data/CE held after OE/WE rise (>=1)
//  RY_TMO     50000  max cycles waiting for RY before error (<2^CNTBITS)
//  CNTBITS    16     width of shared timing/timeout counter
// PORTS
//  wb_clk_i     in   1                  clock
//  wb_rst_i     in   1                  reset: synchronous, active-high
//  wb_adr_i     in   CSBITS+ADDRBITS    {chip index, word address}
//  wb_dat_i     in   DATABITS           write data
//  wb_we_i      in   1                  1 = write
//  wb_stb_i     in   1                  strobe
//  wb_cyc_i     in   1                  cycle
//  wb_stall_o   out  1                  1 = not accepting
//  wb_ack_o     out  1                  1-cycle ack
//  wb_err_o     out  1                  1-cycle error (bad chip index / RY timeout)
//  wb_dat_o     out  DATABITS           read data, valid with ack
//  nor_ry_i     in   NCHIPS             async RY/BY#, 1 = ready
//  nor_data_i   in   DATABITS           bus data in
//  nor_data_o   out  DATABITS           bus data out
//  nor_addr_o   out  ADDRBITS           bus address
//  nor_ce_o     out  NCHIPS             chip enables, active low
//  nor_we_o     out  1                  write enable, active low
//  nor_oe_o     out  1                  output enable, active low
//  nor_data_oe  out  1                  0 = input, 1 = drive nor_data_o
// BEHAVIOUR
//  - Reset (sync, priority over all): state IDLE; ce_o all 1, we_o=1, oe_o=1, data_oe=0, addr/data_o=0,
//    ack/err=0, dat_o=0, stall=0, RY sync flops=0. Reset mid-operation: bus idle on the very next edge.
//  - All outputs registered. stall_o=0 only in IDLE. Accept = stb&cyc&!stall; latch cs, adr, dat, we.
//  - FSM: IDLE -> CHK -> WAIT_RDY -> SETUP -> ACCESS -> HOLD -> DONE -> IDLE.
//    CHK: cs>=NCHIPS -> DONE with err (no bus activity, ce stays high); else WAIT_RDY.
//    WAIT_RDY: ry_sync[cs]=1 -> SETUP; counter reaching RY_TMO -> DONE with err, ce stays high.
//    SETUP: ce[cs]=0, addr driven, write: data_oe=1 and data_o driven; TSETUP cycles.
//    ACCESS: read: oe=0 TRD cycles, dat_o<=nor_data_i on last; write: we=0 TWR cycles.
//    HOLD: oe=we=1, ce/addr/data unchanged, THOLD cycles. DONE: ce all 1, data_oe=0, ack or err for 1 cycle.
//  - Exactly one of ack/err per accepted request, never both. ACK latency from accept edge with RY
//    already high: 4+TSETUP+TRD+THOLD cycles (read), 4+TSETUP+TWR+THOLD (write), incl. 2-flop RY sync.
//  - CE one-hot-low; never more than one chip selected; OE and WE never low simultaneously.
//  - cyc drop mid-transfer: read in SETUP/ACCESS -> HOLD then IDLE, no ack; write always completes the
//    WE pulse and HOLD (never truncated), then returns to IDLE with no ack; WAIT_RDY -> IDLE immediately.
//  - stb while stalled: ignored, not queued. Counter reloads on each state entry; no wrap-around.
// STRUCTURE
//  - Shared pkg/include (next to cmd_defs.vh): state encodings, default timing constants.
//  - One sub-module: nor_ry_sync (NCHIPS-wide 2-flop synchroniser, reset to 0). Rest is one FSM + counter.
// TESTING (NCHIPS=2, TSETUP=1, TRD=8, TWR=4, THOLD=1, RY_TMO=100, RY held high unless stated)
//  - Read chip1 adr 0x0000123, model drives 0xBEEF -> ce_o=2'b01, oe low 8 cycles, ack 14 cycles
//    after accept, dat_o=0xBEEF.
//  - Write chip0 adr 0x3FFFFFF dat 0x5A5A -> ce_o=2'b10, data_oe=1 from SETUP to DONE, we low exactly
//    4 cycles, ack 10 cycles after accept.
//  - ry_i[0]=0 for 20 cycles then 1 -> ce stays high until ry seen + sync; ack 20+ cycles later than base.
//  - ry_i[1] stuck 0 -> err 1 cycle after timeout, no ack, nor_ce_o/oe/we never asserted.
//  - cyc dropped 2 cycles into write ACCESS -> we low full 4 cycles, no ack/err, stall clears after HOLD.
//  - wb_rst_i asserted mid-read ACCESS -> next edge: ce=2'b11, oe=1, stall=0; next read behaves normally.

Source files
------------

// File: rtl/nor_bus_multi_pkg.sv
// rtl/nor_bus_multi_pkg.sv - state encodings, default timing and chip-select width helper
package nor_bus_multi_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHK    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int DEF_TSETUP = 1;
  localparam int DEF_TRD    = 8;
  localparam int DEF_TWR    = 4;
  localparam int DEF_THOLD  = 1;
  localparam int DEF_RY_TMO = 50000;

  function automatic int cs_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nor_bus_multi_if.sv
// rtl/nor_bus_multi_if.sv - pipelined Wishbone slave port bundle
interface nor_bus_multi_if #(
  parameter int CSBITS   = 1,
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic [CSBITS+ADDRBITS-1:0] wb_adr_i;
  logic [DATABITS-1:0]        wb_dat_i;
  logic                       wb_we_i;
  logic                       wb_stb_i;
  logic                       wb_cyc_i;
  logic                       wb_stall_o;
  logic                       wb_ack_o;
  logic                       wb_err_o;
  logic [DATABITS-1:0]        wb_dat_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/nor_bus_multi_ry_sync.sv
// rtl/nor_bus_multi_ry_sync.sv - NCHIPS-wide two-flop synchroniser for RY/BY#
module nor_ry_sync #(
  parameter int NCHIPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCHIPS-1:0] ry_i,
  output logic [NCHIPS-1:0] ry_sync_o
);
  logic [NCHIPS-1:0] meta_q, meta_d;
  logic [NCHIPS-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = ry_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign ry_sync_o = sync_q;
endmodule

// File: rtl/nor_bus_multi.sv
// rtl/nor_bus_multi.sv - single-outstanding Wishbone slave timing NCHIPS NOR devices on a shared bus
module nor_bus_multi
  import nor_bus_multi_pkg::*;
#(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int NCHIPS   = 2,
  parameter int TSETUP   = DEF_TSETUP,
  parameter int TRD      = DEF_TRD,
  parameter int TWR      = DEF_TWR,
  parameter int THOLD    = DEF_THOLD,
  parameter int RY_TMO   = DEF_RY_TMO,
  parameter int CNTBITS  = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  nor_bus_multi_if.slave      wb,
  input  logic [NCHIPS-1:0]   nor_ry_i,
  input  logic [DATABITS-1:0] nor_data_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic [ADDRBITS-1:0] nor_addr_o,
  output logic [NCHIPS-1:0]   nor_ce_o,
  output logic                nor_we_o,
  output logic                nor_oe_o,
  output logic                nor_data_oe
);
  localparam int CSBITS = cs_bits(NCHIPS);

  logic [2:0]          state_q, state_d;
  logic [CNTBITS-1:0]  cnt_q, cnt_d;
  logic [CSBITS-1:0]   cs_q, cs_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] dat_q, dat_d;
  logic                we_q, we_d;
  logic                abort_q, abort_d;
  logic                err_pend_q, err_pend_d;

  logic                stall_q, stall_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATABITS-1:0] rdat_q, rdat_d;
  logic [NCHIPS-1:0]   ce_q, ce_d;
  logic                oe_q, oe_d;
  logic                nwe_q, nwe_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] bdat_q, bdat_d;
  logic                doe_q, doe_d;

  logic [NCHIPS-1:0]   ry_sync;
  logic [NCHIPS-1:0]   ce_sel;
  logic                ry_sel, accept, abort_now, phase_done, busy;
  logic [CNTBITS-1:0]  phase_last;

  nor_ry_sync #(.NCHIPS(NCHIPS)) u_ry_sync (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .ry_i      (nor_ry_i),
    .ry_sync_o (ry_sync)
  );

  always_comb begin
    ce_sel     = ~(NCHIPS'(1) << cs_q);
    ry_sel     = |(ry_sync & ~ce_sel);
    accept     = (state_q == S_IDLE) && wb.wb_stb_i && wb.wb_cyc_i && !stall_q;
    abort_now  = abort_q || !wb.wb_cyc_i;
    phase_last = '0;
    case (state_q)
      S_SETUP:  phase_last = CNTBITS'(TSETUP - 1);
      S_ACCESS: phase_last = we_q ? CNTBITS'(TWR - 1) : CNTBITS'(TRD - 1);
      S_HOLD:   phase_last = CNTBITS'(THOLD - 1);
      default:  phase_last = '0;
    endcase
    phase_done = (cnt_q == phase_last);
  end

  // Reads may be cut short on cyc drop; a started write always finishes its WE pulse and hold.
  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    err_pend_d = err_pend_q;
    abort_d    = (state_q == S_IDLE) ? 1'b0 : abort_now;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d    = S_CHK;
        cs_d       = wb.wb_adr_i[ADDRBITS +: CSBITS];
        adr_d      = wb.wb_adr_i[ADDRBITS-1:0];
        dat_d      = wb.wb_dat_i;
        we_d       = wb.wb_we_i;
        err_pend_d = 1'b0;
      end
      S_CHK: begin
        if (abort_now) state_d = S_IDLE;
        else if (int'(cs_q) >= NCHIPS) begin
          state_d    = S_DONE;
          err_pend_d = 1'b1;
        end else state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort_now) state_d = S_IDLE;
        else if (ry_sel) state_d = S_SETUP;
        else if (cnt_q >= CNTBITS'(RY_TMO - 1)) begin
          state_d    = S_DONE;
          err_pend_d = 1'b1;
        end
      end
      S_SETUP: begin
        if (!we_q && abort_now) state_d = S_HOLD;
        else if (phase_done) state_d = S_ACCESS;
      end
      S_ACCESS: if ((!we_q && abort_now) || phase_done) state_d = S_HOLD;
      S_HOLD:   if (phase_done) state_d = abort_now ? S_IDLE : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + CNTBITS'(1);
    else                    cnt_d = cnt_q;
  end

  // Bus/Wishbone outputs are registered from the current state, so they trail it by one cycle.
  always_comb begin
    busy    = (state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_HOLD);
    stall_d = (state_d != S_IDLE) || (state_q != S_IDLE);
    ack_d   = (state_q == S_DONE) && !err_pend_q;
    err_d   = (state_q == S_DONE) && err_pend_q;
    ce_d    = busy ? ce_sel : '1;
    oe_d    = !((state_q == S_ACCESS) && !we_q);
    nwe_d   = !((state_q == S_ACCESS) && we_q);
    addr_d  = busy ? adr_q : addr_q;
    bdat_d  = (busy && we_q) ? dat_q : bdat_q;
    doe_d   = busy && we_q;
    rdat_d  = (!oe_q && oe_d) ? nor_data_i : rdat_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cs_q       <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      abort_q    <= 1'b0;
      err_pend_q <= 1'b0;
      stall_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
      ce_q       <= '1;
      oe_q       <= 1'b1;
      nwe_q      <= 1'b1;
      addr_q     <= '0;
      bdat_q     <= '0;
      doe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      abort_q    <= abort_d;
      err_pend_q <= err_pend_d;
      stall_q    <= stall_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      nwe_q      <= nwe_d;
      addr_q     <= addr_d;
      bdat_q     <= bdat_d;
      doe_q      <= doe_d;
    end
  end

  assign wb.wb_stall_o = stall_q;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_dat_o   = rdat_q;
  assign nor_ce_o      = ce_q;
  assign nor_oe_o      = oe_q;
  assign nor_we_o      = nwe_q;
  assign nor_addr_o    = addr_q;
  assign nor_data_o    = bdat_q;
  assign nor_data_oe   = doe_q;
endmodule

// File: tb/tb_nor_bus_multi.sv
// tb/tb_nor_bus_multi.sv - self-checking bench for nor_bus_multi with a NOR device model
module tb_nor_bus_multi;
  localparam int TSETUP = 1, TRD = 8, TWR = 4, THOLD = 1, RY_TMO = 100;
  localparam int RD_LAT = 4 + TSETUP + TRD + THOLD;
  localparam int WR_LAT = 4 + TSETUP + TWR + THOLD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nor_bus_multi_if #(.CSBITS(1), .ADDRBITS(26), .DATABITS(16)) wbif();

  logic [1:0]  ry = 2'b11;
  logic [15:0] nor_data_i, nor_data_o;
  logic [25:0] nor_addr;
  logic [1:0]  ce;
  logic        nwe, noe, doe;

  nor_bus_multi #(
    .ADDRBITS(26), .DATABITS(16), .NCHIPS(2), .TSETUP(TSETUP), .TRD(TRD),
    .TWR(TWR), .THOLD(THOLD), .RY_TMO(RY_TMO), .CNTBITS(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wbif),
    .nor_ry_i   (ry),
    .nor_data_i (nor_data_i),
    .nor_data_o (nor_data_o),
    .nor_addr_o (nor_addr),
    .nor_ce_o   (ce),
    .nor_we_o   (nwe),
    .nor_oe_o   (noe),
    .nor_data_oe(doe)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Device model: per-chip word memories, unwritten words read a fixed address hash.
  logic [15:0] dev_mem [bit [26:0]];
  logic [15:0] ref_mem [bit [26:0]];

  function automatic logic [15:0] dflt(input bit [26:0] k);
    return k[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] ref_rd(input bit [26:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
  endfunction

  always @(noe, ce, nor_addr) begin
    bit [26:0] k;
    k = {ce == 2'b01, nor_addr};
    if (!noe && ce != 2'b11) nor_data_i = dev_mem.exists(k) ? dev_mem[k] : dflt(k);
    else nor_data_i = 16'h0;
  end

  always @(posedge nwe) begin
    if (ce == 2'b10 || ce == 2'b01) begin
      chk("we_rise_doe", {63'd0, doe}, 64'd1);
      dev_mem[{ce == 2'b01, nor_addr}] = nor_data_o;
    end
  end

  int mon_oe, mon_we, mon_ce, mon_doe, mon_ack, mon_err;
  logic [1:0] mon_ce_and;

  task automatic clr_mon();
    mon_oe = 0; mon_we = 0; mon_ce = 0; mon_doe = 0; mon_ack = 0; mon_err = 0;
    mon_ce_and = 2'b11;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("bus_invariant", {63'd0, ((ce == 2'b11) || $onehot(~ce)) && !(!noe && !nwe)}, 64'd1);
      chk("ack_err_excl", {63'd0, wbif.wb_ack_o && wbif.wb_err_o}, 64'd0);
      if (!noe) mon_oe++;
      if (!nwe) mon_we++;
      if (ce != 2'b11) mon_ce++;
      if (doe) mon_doe++;
      if (wbif.wb_ack_o) mon_ack++;
      if (wbif.wb_err_o) mon_err++;
      mon_ce_and = mon_ce_and & ce;
    end
  end

  // lat = edge (counted from the accept edge) on which the master takes ack/err.
  task automatic run_txn(input logic w, input logic cs, input logic [25:0] a,
                         input logic [15:0] d, output int lat, output logic [15:0] rd);
    int  n;
    bit  done;
    @(negedge clk);
    clr_mon();
    wbif.wb_adr_i = {cs, a};
    wbif.wb_dat_i = d;
    wbif.wb_we_i  = w;
    wbif.wb_stb_i = 1'b1;
    wbif.wb_cyc_i = 1'b1;
    @(posedge clk);
    #1 wbif.wb_stb_i = 1'b0;
    n = 0; done = 0; lat = -1; rd = '0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1 n++;
      if (wbif.wb_ack_o || wbif.wb_err_o) begin
        done = 1;
        lat  = n + 1;
        rd   = wbif.wb_dat_o;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no ack/err within %0d cycles", n);
    end
    wbif.wb_cyc_i = 1'b0;
    n = 0;
    while (wbif.wb_stall_o && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    @(negedge clk);
    chk("stall_clear", {63'd0, wbif.wb_stall_o}, 64'd0);
  endtask

  task automatic check_txn(input string tag, input logic w, input int lat, input int exp_lat,
                           input logic [1:0] exp_ce, input logic [15:0] rd, input logic [15:0] exp_rd);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ce"}, {62'd0, mon_ce_and}, {62'd0, exp_ce});
    chk({tag, "_ce_cycles"}, 64'(mon_ce), 64'(TSETUP + (w ? TWR : TRD) + THOLD));
    chk({tag, "_oe_cycles"}, 64'(mon_oe), 64'(w ? 0 : TRD));
    chk({tag, "_we_cycles"}, 64'(mon_we), 64'(w ? TWR : 0));
    chk({tag, "_doe_cycles"}, 64'(mon_doe), 64'(w ? (TSETUP + TWR + THOLD) : 0));
    chk({tag, "_acks"}, 64'(mon_ack), 64'd1);
    chk({tag, "_errs"}, 64'(mon_err), 64'd0);
    if (!w) chk({tag, "_rdata"}, {48'd0, rd}, {48'd0, exp_rd});
  endtask

  typedef struct {
    logic        w;
    logic        cs;
    logic [25:0] adr;
    logic [15:0] dat;
    int          lat;
    logic [1:0]  ce;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat, n;
    logic [15:0] rd, d;
    logic        w, cs;
    logic [25:0] a;
    logic [1:0]  exp_ce;

    vecs[0] = '{1'b0, 1'b1, 26'h0000123, 16'h0000, RD_LAT, 2'b01, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 26'h3FFFFFF, 16'h5A5A, WR_LAT, 2'b10, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 26'h3FFFFFF, 16'h0000, RD_LAT, 2'b10, 16'h5A5A};
    vecs[3] = '{1'b1, 1'b1, 26'h0000000, 16'h0001, WR_LAT, 2'b01, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 26'h0000000, 16'h0000, RD_LAT, 2'b01, 16'h0001};
    vecs[5] = '{1'b0, 1'b0, 26'h0000000, 16'h0000, RD_LAT, 2'b10, 16'hC3A5};

    dev_mem[{1'b1, 26'h0000123}] = 16'hBEEF;
    ref_mem[{1'b1, 26'h0000123}] = 16'hBEEF;
    wbif.wb_adr_i = '0; wbif.wb_dat_i = '0; wbif.wb_we_i = 1'b0;
    wbif.wb_stb_i = 1'b0; wbif.wb_cyc_i = 1'b0;
    clr_mon();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce", {62'd0, ce}, 64'd3);
    chk("rst_oe_we", {62'd0, noe, nwe}, 64'd3);
    chk("rst_doe", {63'd0, doe}, 64'd0);
    chk("rst_stall_ack_err", {61'd0, wbif.wb_stall_o, wbif.wb_ack_o, wbif.wb_err_o}, 64'd0);
    chk("rst_dat_o", {48'd0, wbif.wb_dat_o}, 64'd0);
    chk("rst_addr_data", {22'd0, nor_addr, nor_data_o}, 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].w, vecs[i].cs, vecs[i].adr, vecs[i].dat, lat, rd);
      check_txn($sformatf("vec%0d", i), vecs[i].w, lat, vecs[i].lat, vecs[i].ce, rd, vecs[i].rd);
      if (vecs[i].w) ref_mem[{vecs[i].cs, vecs[i].adr}] = vecs[i].dat;
    end

    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      cs = 1'($urandom_range(0, 1));
      a  = 26'($urandom_range(0, 7));
      d  = 16'($urandom);
      exp_ce = 2'b11;
      exp_ce[cs] = 1'b0;
      run_txn(w, cs, a, d, lat, rd);
      check_txn($sformatf("rnd%0d", i), w, lat, w ? WR_LAT : RD_LAT, exp_ce, rd, ref_rd({cs, a}));
      if (w) ref_mem[{cs, a}] = d;
    end

    // RY low for 20 cycles after accept on chip 0
    @(negedge clk) ry[0] = 1'b0;
    fork
      run_txn(1'b0, 1'b0, 26'h0000005, 16'h0, lat, rd);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (20) @(negedge clk);
        ry[0] = 1'b1;
      end
    join
    chk_range("rydly_lat", lat, RD_LAT + 20, RD_LAT + 23);
    chk("rydly_ce_cycles", 64'(mon_ce), 64'(TSETUP + TRD + THOLD));
    chk("rydly_rdata", {48'd0, rd}, {48'd0, ref_rd({1'b0, 26'h0000005})});
    chk("rydly_ack", 64'(mon_ack), 64'd1);

    // RY stuck low on chip 1: timeout error, bus untouched
    @(negedge clk) ry[1] = 1'b0;
    run_txn(1'b0, 1'b1, 26'h0000009, 16'h0, lat, rd);
    chk_range("tmo_lat", lat, RY_TMO + 1, RY_TMO + 6);
    chk("tmo_err", 64'(mon_err), 64'd1);
    chk("tmo_ack", 64'(mon_ack), 64'd0);
    chk("tmo_bus_idle", 64'(mon_ce + mon_oe + mon_we), 64'd0);
    @(negedge clk) ry[1] = 1'b1;
    repeat (3) @(posedge clk);

    // cyc dropped two cycles into the write WE pulse
    @(negedge clk);
    clr_mon();
    wbif.wb_adr_i = {1'b0, 26'h0000055}; wbif.wb_dat_i = 16'h1234; wbif.wb_we_i = 1'b1;
    wbif.wb_stb_i = 1'b1; wbif.wb_cyc_i = 1'b1;
    @(posedge clk);
    #1 wbif.wb_stb_i = 1'b0;
    n = 0;
    while (mon_we < 2 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    wbif.wb_cyc_i = 1'b0;
    n = 0;
    while (wbif.wb_stall_o && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("abort_stall", {63'd0, wbif.wb_stall_o}, 64'd0);
    chk("abort_ce_at_unstall", {62'd0, ce}, 64'd3);
    chk("abort_we_at_unstall", {63'd0, nwe}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_we_cycles", 64'(mon_we), 64'(TWR));
    chk("abort_ack_err", 64'(mon_ack + mon_err), 64'd0);
    ref_mem[{1'b0, 26'h0000055}] = 16'h1234;
    run_txn(1'b0, 1'b0, 26'h0000055, 16'h0, lat, rd);
    check_txn("abort_rb", 1'b0, lat, RD_LAT, 2'b10, rd, 16'h1234);

    // reset in the middle of a read access
    @(negedge clk);
    clr_mon();
    wbif.wb_adr_i = {1'b1, 26'h0000077}; wbif.wb_we_i = 1'b0;
    wbif.wb_stb_i = 1'b1; wbif.wb_cyc_i = 1'b1;
    @(posedge clk);
    #1 wbif.wb_stb_i = 1'b0;
    n = 0;
    while (mon_oe < 3 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ce", {62'd0, ce}, 64'd3);
    chk("midrst_oe", {63'd0, noe}, 64'd1);
    chk("midrst_stall", {63'd0, wbif.wb_stall_o}, 64'd0);
    wbif.wb_cyc_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    run_txn(1'b0, 1'b1, 26'h0000077, 16'h0, lat, rd);
    check_txn("postrst", 1'b0, lat, RD_LAT, 2'b01, rd, ref_rd({1'b1, 26'h0000077}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
